// File: rtl/network_controller.sv
// Two-neuron MAC engine: 4x8 signed dot products plus bias, followed by a clamped ReLU.
// Operands come from a 4x32 bank that is loaded from the ROM port while the engine is idle.
module network_controller #(
  parameter logic [15:0] SAT_MAX = 16'd32767
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rom_output,
  input  logic [1:0]  address,
  input  logic        writeData,
  input  logic        start_network_controller,
  output logic        busy,
  output logic        done,
  output logic [15:0] result0,
  output logic [15:0] result1,
  output logic        overrun
);

  localparam int unsigned ACC_W = 20;
  localparam int unsigned NBANK = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_BIAS = 2'd2;
  localparam logic [1:0] S_ACT  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
  logic                    busy_d, done_d, overrun_d;
  logic [15:0]             res0_d, res1_d;
  logic [31:0]             bank_q [NBANK];

  logic [31:0]             w_word;
  logic signed [7:0]       x_byte, w_byte;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext, bias0_ext, bias1_ext;
  logic                    bank_we;

  // ReLU with an upper clamp at SAT_MAX
  function automatic logic [15:0] relu_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] lim;
    lim = $signed({4'b0000, SAT_MAX});
    if (a < 0)
      relu_sat = 16'd0;
    else if (a > lim)
      relu_sat = SAT_MAX;
    else
      relu_sat = a[15:0];
  endfunction

  // Operand selection: cnt[2] picks the neuron, cnt[1:0] the byte lane
  always_comb begin
    w_word    = cnt_q[2] ? bank_q[2] : bank_q[1];
    x_byte    = $signed(bank_q[0][{cnt_q[1:0], 3'b000} +: 8]);
    w_byte    = $signed(w_word[{cnt_q[1:0], 3'b000} +: 8]);
    prod      = x_byte * w_byte;
    prod_ext  = $signed({{(ACC_W-16){prod[15]}}, prod});
    bias0_ext = $signed({{(ACC_W-16){bank_q[3][15]}}, bank_q[3][15:0]});
    bias1_ext = $signed({{(ACC_W-16){bank_q[3][31]}}, bank_q[3][31:16]});
  end

  assign bank_we = (state_q == S_IDLE) && writeData;

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc0_d    = acc0_q;
    acc1_d    = acc1_q;
    busy_d    = busy;
    done_d    = 1'b0;
    res0_d    = result0;
    res1_d    = result1;
    overrun_d = overrun | ((state_q != S_IDLE) && (writeData || start_network_controller));

    case (state_q)
      S_IDLE: begin
        if (start_network_controller) begin
          state_d = S_MAC;
          cnt_d   = 3'd0;
          acc0_d  = '0;
          acc1_d  = '0;
          busy_d  = 1'b1;
        end
      end
      S_MAC: begin
        if (cnt_q[2])
          acc1_d = acc1_q + prod_ext;
        else
          acc0_d = acc0_q + prod_ext;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7)
          state_d = S_BIAS;
      end
      S_BIAS: begin
        acc0_d  = acc0_q + bias0_ext;
        acc1_d  = acc1_q + bias1_ext;
        state_d = S_ACT;
      end
      S_ACT: begin
        res0_d  = relu_sat(acc0_q);
        res1_d  = relu_sat(acc1_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result0 <= '0;
      result1 <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      busy    <= busy_d;
      done    <= done_d;
      result0 <= res0_d;
      result1 <= res1_d;
      overrun <= overrun_d;
    end
  end

  // Register bank; writes land only while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBANK; i++) bank_q[i] <= '0;
    end else if (bank_we) begin
      bank_q[address] <= rom_output;
    end
  end

endmodule

// File: tb/tb_network_controller.sv
// Randomized and directed bench for network_controller: scoreboard of expected results
// and done timing, checked by an independent monitor against an arithmetic reference model.
module tb_network_controller;

  localparam int SAT = 32767;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rom_output;
  logic [1:0]  address;
  logic        writeData;
  logic        start_network_controller;
  logic        busy, done, overrun;
  logic [15:0] result0, result1;

  typedef struct {
    int r0;
    int r1;
    int cyc;
  } exp_t;

  exp_t        sb[$];
  int          done_cycles[$];
  logic [31:0] shadow [4];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  network_controller #(.SAT_MAX(16'd32767)) dut (
    .clk(clk),
    .reset(reset),
    .rom_output(rom_output),
    .address(address),
    .writeData(writeData),
    .start_network_controller(start_network_controller),
    .busy(busy),
    .done(done),
    .result0(result0),
    .result1(result1),
    .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: dot product of signed bytes plus signed bias, then clamped ReLU
  function automatic int model_neuron(input int n);
    int sum;
    logic [31:0] x, w;
    logic [15:0] b;
    x = shadow[0];
    w = shadow[1 + n];
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      logic signed [7:0] xs, ws;
      xs = $signed(x[8*k +: 8]);
      ws = $signed(w[8*k +: 8]);
      sum += int'(xs) * int'(ws);
    end
    b = (n == 0) ? shadow[3][15:0] : shadow[3][31:16];
    sum += int'($signed(b));
    if (sum < 0) return 0;
    if (sum > SAT) return SAT;
    return sum;
  endfunction

  // Monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (done) begin
      done_cycles.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result0", int'(result0), e.r0);
        check("result1", int'(result1), e.r1);
        check("done_cycle", cyc, e.cyc);
        check("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic write_bank(input logic [1:0] a, input logic [31:0] d);
    writeData = 1'b1; address = a; rom_output = d;
    @(posedge clk); #1;
    writeData = 1'b0;
    shadow[a] = d;
  endtask

  task automatic load(input logic [31:0] b0, b1, b2, b3);
    write_bank(2'd0, b0); write_bank(2'd1, b1);
    write_bank(2'd2, b2); write_bank(2'd3, b3);
  endtask

  // Issue a start (optionally with a simultaneous write) and queue the expected result
  task automatic issue_start(input bit wr, input logic [1:0] a, input logic [31:0] d);
    exp_t e;
    start_network_controller = 1'b1;
    writeData = wr; address = a; rom_output = d;
    @(posedge clk); #1;
    start_network_controller = 1'b0; writeData = 1'b0;
    if (wr) shadow[a] = d;
    e.r0 = model_neuron(0); e.r1 = model_neuron(1); e.cyc = cyc + 10;
    sb.push_back(e);
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) begin
      check("wait_idle_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) shadow[i] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rom_output = '0; address = '0; writeData = 1'b0;
    start_network_controller = 1'b0;
    for (int i = 0; i < 4; i++) shadow[i] = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result0", int'(result0), 0);
    check("rst_result1", int'(result1), 0);
    check("rst_overrun", int'(overrun), 0);
    // Start held during reset must be ignored
    start_network_controller = 1'b1;
    @(posedge clk); #1;
    start_network_controller = 1'b0;
    check("start_in_reset_busy", int'(busy), 0);
    reset = 1'b0;

    // Basic case
    load(32'h04030201, 32'h01010101, 32'hFFFFFFFF, 32'h00030005);
    issue_start(0, 2'd0, 32'h0);
    wait_idle();
    check("basic_result0_hold", int'(result0), 15);

    // Saturation and extreme negative operands
    load(32'h7F7F7F7F, 32'h7F7F7F7F, 32'h80808080, 32'h80007FFF);
    issue_start(0, 2'd0, 32'h0);
    wait_idle();
    load(32'h80808080, 32'h80808080, 32'h00000000, 32'h00008000);
    issue_start(0, 2'd0, 32'h0);
    wait_idle();

    // Simultaneous write and start: computation sees the new bias
    issue_start(1, 2'd3, 32'hFFF00010);
    wait_idle();

    // Randomized operands
    for (int it = 0; it < 25; it++) begin
      load($urandom, $urandom, $urandom, $urandom);
      issue_start(0, 2'd0, 32'h0);
      wait_idle();
    end

    // Busy collisions at MAC cycle 3
    load(32'h04030201, 32'h01010101, 32'hFFFFFFFF, 32'h00030005);
    check("overrun_before", int'(overrun), 0);
    issue_start(0, 2'd0, 32'h0);
    repeat (3) @(posedge clk); #1;
    writeData = 1'b1; address = 2'd0; rom_output = 32'h0;
    start_network_controller = 1'b1;
    @(posedge clk); #1;
    writeData = 1'b0; start_network_controller = 1'b0;
    wait_idle();
    repeat (15) @(posedge clk); #1;
    check("overrun_after_collision", int'(overrun), 1);
    issue_start(0, 2'd0, 32'h0);
    wait_idle();
    check("overrun_sticky", int'(overrun), 1);

    // Reset at MAC cycle 5
    issue_start(0, 2'd0, 32'h0);
    repeat (5) @(posedge clk); #1;
    do_reset();
    void'(sb.pop_back());
    check("midrst_busy", int'(busy), 0);
    check("midrst_result0", int'(result0), 0);
    check("midrst_result1", int'(result1), 0);
    check("midrst_overrun", int'(overrun), 0);
    repeat (15) @(posedge clk); #1;
    check("midrst_result0_later", int'(result0), 0);
    // Bank was cleared: a start with the wiped bank yields zeros
    issue_start(0, 2'd0, 32'h0);
    wait_idle();
    load(32'h04030201, 32'h01010101, 32'hFFFFFFFF, 32'h00030005);
    issue_start(0, 2'd0, 32'h0);
    wait_idle();

    // Back-to-back: restart on the cycle done is visible
    load(32'h11223344, 32'hF0E0D0C0, 32'h01020304, 32'h12340100);
    issue_start(0, 2'd0, 32'h0);
    begin
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (done) begin seen = 1; break; end
      end
      check("b2b_first_done_seen", int'(seen), 1);
    end
    issue_start(1, 2'd1, 32'h7F80017F);
    wait_idle();
    if (done_cycles.size() >= 2)
      check("b2b_spacing", done_cycles[done_cycles.size()-1] - done_cycles[done_cycles.size()-2], 11);
    else
      check("b2b_done_count", done_cycles.size(), 2);

    repeat (5) @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
